// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame defaults, and the
// board clock/baud figures benches use to derive the oversample tick period.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_OS_RATE   = 16;
  localparam int CLK_FREQ       = 25000000;
  localparam int BAUD           = 9600;
  localparam int TICK_DIV       = CLK_FREQ / (BAUD * UART_OS_RATE);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BRK
  } rx_state_t;

endpackage

// File: rtl/uart_rx_os16_if.sv
// Receiver-side bundle: oversample tick and serial line in; byte, strobes and busy out.
// The master side drives tick/line, the slave side is the receiver.
interface uart_rx_os16_if
  import uart_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS
);

  logic                 tick_os;
  logic                 rx;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 frame_err;
  logic                 busy;

  modport master (output tick_os, rx, input rx_data, rx_valid, frame_err, busy);
  modport slave  (input tick_os, rx, output rx_data, rx_valid, frame_err, busy);

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous pin; 2 cycles of latency, no backpressure.
// Reset loads INIT so an idle-high line does not look like an edge after reset.
module sync_2ff #(
  parameter logic INIT = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= INIT;
      q    <= INIT;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_os16.sv
// UART receiver with 16x oversampling; strobe lands one cycle after the mid-stop tick
// (~9.5 bit times after the start edge). No backpressure: the consumer must take each strobe.
module uart_rx_os16
  import uart_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS,
  parameter int OS_RATE   = UART_OS_RATE
) (
  input logic           clk_in,
  input logic           rst,
  uart_rx_os16_if.slave bus
);

  localparam int OSW = $clog2(OS_RATE);
  localparam int BCW = $clog2(DATA_BITS + 1);
  localparam logic [OSW-1:0] OS_MID   = OSW'(OS_RATE / 2 - 1);
  localparam logic [OSW-1:0] OS_LAST  = OSW'(OS_RATE - 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_BITS - 1);

  logic rx_s;

  rx_state_t            state_q, state_d;
  logic [OSW-1:0]       os_q, os_d;
  logic [BCW-1:0]       bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;

  sync_2ff #(.INIT(1'b1)) u_sync (
    .clk (clk_in),
    .rst (rst),
    .d   (bus.rx),
    .q   (rx_s)
  );

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      os_q    <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      os_q    <= os_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    os_d    = os_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    if (bus.tick_os) begin
      unique case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_d = START;
            os_d    = '0;
          end
        end
        START: begin
          // A start bit that is high again at its midpoint was only a glitch.
          if (os_q == OS_MID) begin
            os_d    = '0;
            bit_d   = '0;
            state_d = rx_s ? IDLE : DATA;
          end else begin
            os_d = os_q + 1'b1;
          end
        end
        DATA: begin
          if (os_q == OS_LAST) begin
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            os_d    = '0;
            bit_d   = bit_q + 1'b1;
            if (bit_q == BIT_LAST) state_d = STOP;
          end else begin
            os_d = os_q + 1'b1;
          end
        end
        STOP: begin
          if (os_q == OS_LAST) begin
            os_d = '0;
            if (rx_s) begin
              data_d  = shift_q;
              valid_d = 1'b1;
              state_d = IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = BRK;
            end
          end else begin
            os_d = os_q + 1'b1;
          end
        end
        BRK: begin
          // Wait out a held-low line so a break is not decoded as zero bytes.
          if (rx_s) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.rx_data   = data_q;
  assign bus.rx_valid  = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_os16.sv
// Bench for uart_rx_os16: table-driven frames, corner sequences and random frames
// checked against a frame-level expectation queue.
module tb_uart_rx_os16;
  import uart_pkg::*;

  localparam int OS  = UART_OS_RATE;
  localparam int TPB = 4;

  logic clk_in = 1'b0;
  logic rst;
  always #5 clk_in = ~clk_in;

  uart_rx_os16_if #(.DATA_BITS(8)) bus ();

  uart_rx_os16 #(.DATA_BITS(8), .OS_RATE(OS)) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus)
  );

  typedef struct {
    logic       is_err;
    logic [7:0] data;
    int         cyc;
  } ev_t;

  typedef struct {
    logic [7:0] d;
    logic       stop;
    int         low_after;
    int         exp_valid;
    int         exp_ferr;
    logic [7:0] exp_data;
    logic       exp_busy;
  } vec_t;

  ev_t        obs_q[$];
  ev_t        exp_q[$];
  logic [7:0] last_good;
  int         n_cmp, n_fail;
  int         cyc;
  int         phase;
  bit         tick_en;
  int         start_cyc;
  vec_t       vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk_in);
      #1;
      cyc++;
      if (bus.rx_valid || bus.frame_err) begin
        chk("exclusive_strobes", 32'(bus.rx_valid & bus.frame_err), 32'(0));
        obs_q.push_back('{bus.frame_err, bus.rx_data, cyc});
      end
    end
  end

  task automatic step();
    @(negedge clk_in);
    if (tick_en) begin
      phase = (phase + 1) % TPB;
      bus.tick_os = (phase == 0);
    end else begin
      bus.tick_os = 1'b0;
    end
  endtask

  task automatic hold_ticks(input int n);
    int k = 0;
    while (k < n) begin
      step();
      if (bus.tick_os) k++;
    end
  endtask

  task automatic idle_bits(input int n);
    bus.rx = 1'b1;
    hold_ticks(n * OS);
  endtask

  task automatic send_bit(input logic b, input int stall);
    bus.rx = b;
    if (stall > 0) begin
      hold_ticks(OS / 2);
      tick_en = 1'b0;
      repeat (stall) step();
      chk("stall_busy", 32'(bus.busy), 32'(1));
      chk("stall_no_strobe", 32'(obs_q.size()), 32'(0));
      tick_en = 1'b1;
      hold_ticks(OS / 2);
    end else begin
      hold_ticks(OS);
    end
  endtask

  // Frame-level model: a high stop bit delivers the byte, a low one flags an
  // error and leaves the previously delivered byte on rx_data.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int stall_bit, input int stall);
    bus.rx = 1'b0;
    start_cyc = cyc;
    send_bit(1'b0, 0);
    for (int i = 0; i < 8; i++) send_bit(d[i], (i == stall_bit) ? stall : 0);
    send_bit(stop, 0);
    if (stop) begin
      exp_q.push_back('{1'b0, d, 0});
      last_good = d;
    end else begin
      exp_q.push_back('{1'b1, last_good, 0});
    end
  endtask

  task automatic check_events(input string tag);
    ev_t o, e;
    chk({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      chk({tag, "_kind"}, 32'(o.is_err), 32'(e.is_err));
      chk({tag, "_data"}, 32'(o.data), 32'(e.data));
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv, nf, lat, gap;
    logic [7:0] rd;
    logic st;
    n_cmp = 0; n_fail = 0;
    phase = 0; tick_en = 1'b1; last_good = 8'h00;
    rst = 1'b1; bus.rx = 1'b1; bus.tick_os = 1'b0;

    vecs[0] = '{8'hA5, 1'b1, 0, 1, 0, 8'hA5, 1'b0};
    vecs[1] = '{8'h55, 1'b0, 3, 0, 1, 8'hA5, 1'b1};
    vecs[2] = '{8'h3C, 1'b1, 0, 1, 0, 8'h3C, 1'b0};
    vecs[3] = '{8'hFF, 1'b0, 0, 0, 1, 8'h3C, 1'b1};
    vecs[4] = '{8'h00, 1'b1, 0, 1, 0, 8'h00, 1'b0};

    repeat (3) step();
    chk("rst_rx_data", 32'(bus.rx_data), 32'(0));
    chk("rst_rx_valid", 32'(bus.rx_valid), 32'(0));
    chk("rst_frame_err", 32'(bus.frame_err), 32'(0));
    chk("rst_busy", 32'(bus.busy), 32'(0));
    step();
    rst = 1'b0;
    idle_bits(2);
    chk("idle_no_strobe", 32'(obs_q.size()), 32'(0));

    for (int v = 0; v < 5; v++) begin
      idle_bits(2);
      send_frame(vecs[v].d, vecs[v].stop, -1, 0);
      if (vecs[v].low_after > 0) begin
        bus.rx = 1'b0;
        hold_ticks(vecs[v].low_after * OS);
      end
      chk("vec_busy_end_of_frame", 32'(bus.busy), 32'(vecs[v].exp_busy));
      idle_bits(2);
      chk("vec_busy_after_idle", 32'(bus.busy), 32'(0));
      nv = 0; nf = 0;
      foreach (obs_q[i]) if (obs_q[i].is_err) nf++; else nv++;
      chk("vec_valid_count", 32'(nv), 32'(vecs[v].exp_valid));
      chk("vec_ferr_count", 32'(nf), 32'(vecs[v].exp_ferr));
      chk("vec_rx_data", 32'(bus.rx_data), 32'(vecs[v].exp_data));
      if (vecs[v].exp_valid == 1 && obs_q.size() == 1) begin
        lat = obs_q[0].cyc - start_cyc;
        chk("vec_latency_in_window", 32'(lat >= 610 && lat <= 616), 32'(1));
      end
      check_events("vec");
    end

    // Short low pulse must be rejected at the start-bit midpoint.
    idle_bits(1);
    bus.rx = 1'b0;
    hold_ticks(4);
    chk("glitch_busy_during", 32'(bus.busy), 32'(1));
    bus.rx = 1'b1;
    hold_ticks(8);
    chk("glitch_busy_after", 32'(bus.busy), 32'(0));
    idle_bits(1);
    check_events("glitch");
    send_frame(8'h3C, 1'b1, -1, 0);
    idle_bits(2);
    check_events("after_glitch");

    idle_bits(2);
    send_frame(8'h00, 1'b1, -1, 0);
    send_frame(8'hFF, 1'b1, -1, 0);
    send_frame(8'h81, 1'b1, -1, 0);
    idle_bits(2);
    chk("b2b_count", 32'(obs_q.size()), 32'(3));
    if (obs_q.size() == 3) begin
      chk("b2b_spacing_1", 32'(obs_q[1].cyc - obs_q[0].cyc), 32'(10 * OS * TPB));
      chk("b2b_spacing_2", 32'(obs_q[2].cyc - obs_q[1].cyc), 32'(10 * OS * TPB));
    end
    check_events("b2b");

    // Reset in the middle of a byte, after data bit 3.
    idle_bits(2);
    rd = 8'hC3;
    send_bit(1'b0, 0);
    for (int i = 0; i < 4; i++) send_bit(rd[i], 0);
    rst = 1'b1;
    #1;
    chk("midrst_rx_data", 32'(bus.rx_data), 32'(0));
    chk("midrst_rx_valid", 32'(bus.rx_valid), 32'(0));
    chk("midrst_frame_err", 32'(bus.frame_err), 32'(0));
    chk("midrst_busy", 32'(bus.busy), 32'(0));
    bus.rx = 1'b1;
    repeat (8) step();
    rst = 1'b0;
    last_good = 8'h00;
    idle_bits(2);
    check_events("abort");
    chk("abort_rx_data", 32'(bus.rx_data), 32'(0));
    send_frame(8'h7E, 1'b1, -1, 0);
    idle_bits(2);
    check_events("post_rst");

    idle_bits(2);
    send_frame(8'hB4, 1'b1, 4, 200);
    idle_bits(2);
    check_events("stall");
    chk("stall_rx_data", 32'(bus.rx_data), 32'(8'hB4));

    for (int r = 0; r < 20; r++) begin
      rd  = 8'($urandom);
      st  = ($urandom_range(0, 3) != 0);
      gap = st ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
      send_frame(rd, st, -1, 0);
      if (gap > 0) idle_bits(gap);
    end
    idle_bits(2);
    check_events("rand");
    chk("rand_final_rx_data", 32'(bus.rx_data), 32'(last_good));
    chk("rand_final_busy", 32'(bus.busy), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
